// File: rtl/codpri_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : codpri_rr_pkg
// Description : Shared constants and helpers for the codpri_rr arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package codpri_rr_pkg;

    // Arbitration mode encodings carried on the modo input
    localparam logic MODO_FIXO = 1'b0;
    localparam logic MODO_RR   = 1'b1;

    // Single-step modulo reduction: operands never exceed 2*n-1 here
    function automatic int unsigned wrap_idx(input int unsigned a, input int unsigned n);
        return (a >= n) ? (a - n) : a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/codpri_n.sv
`default_nettype none
// ============================================================================
// Module      : codpri_n
// Description : Combinational N-input fixed-priority encoder, highest index
//               wins. Outputs the winning index and an any-request flag.
// Revision    : 1.0 - initial release
// ============================================================================
module codpri_n #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan upward so the last (highest) set bit overwrites lower ones
    always_comb begin
        idx = '0;
        any = 1'b0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    idx = W'(i);
                    any = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/codpri_rr.sv
`default_nettype none
// ============================================================================
// Module      : codpri_rr
// Description : Registered N-way priority encoder / arbiter with fixed
//               (highest index wins) and round-robin modes, plus grant hold.
// Revision    : 1.0 - initial release
// ============================================================================
module codpri_rr
    import codpri_rr_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    input  logic         modo,
    input  logic         hold,
    output logic [W-1:0] y,
    output logic         v
);

    // Pointer reset value: index N-1 holds top priority after reset/fixed mode
    localparam logic [W-1:0] C_PTR_TOP = W'(N - 1);

    logic [W-1:0] r_y;
    logic         r_v;
    logic [W-1:0] r_ptr;

    logic [N-1:0] w_rot;
    logic [N-1:0] w_enc_in;
    logic [W-1:0] w_enc_idx;
    logic         w_enc_any;
    logic [W-1:0] w_rr_y;
    logic         w_lock;
    logic [W-1:0] w_y_nxt;
    logic         w_v_nxt;
    logic [W-1:0] w_ptr_nxt;

    // Rotate req so that original index ptr lands on rotated bit N-1,
    // ptr-1 on N-2, and so on with wrap-around; rotated bit j maps back
    // to original index (j + ptr + 1) mod N.
    always_comb begin
        w_rot = '0;
        for (int j = 0; j < N; j++) begin
            w_rot[j] = req[wrap_idx(32'(j) + 32'(r_ptr) + 32'd1, 32'(N))];
        end
    end

    assign w_enc_in = (modo == MODO_RR) ? w_rot : req;

    codpri_n #(
        .N (N),
        .W (W)
    ) u_enc (
        .req (w_enc_in),
        .en  (en),
        .idx (w_enc_idx),
        .any (w_enc_any)
    );

    // Undo the rotation to recover the winner's real index
    assign w_rr_y = W'(wrap_idx(32'(w_enc_idx) + 32'(r_ptr) + 32'd1, 32'(N)));

    // Lock only applies to a live grant whose requester is still asking
    assign w_lock = hold && r_v && req[r_y];

    // Next-state selection in priority order: disable, lock, idle, grant
    always_comb begin
        w_y_nxt   = r_y;
        w_v_nxt   = r_v;
        w_ptr_nxt = r_ptr;
        if (!en) begin
            w_y_nxt = '0;
            w_v_nxt = 1'b0;
        end else if (w_lock) begin
            w_y_nxt = r_y;
            w_v_nxt = r_v;
        end else if (!w_enc_any) begin
            w_y_nxt = '0;
            w_v_nxt = 1'b0;
        end else if (modo == MODO_FIXO) begin
            w_y_nxt   = w_enc_idx;
            w_v_nxt   = 1'b1;
            w_ptr_nxt = C_PTR_TOP;
        end else begin
            w_y_nxt   = w_rr_y;
            w_v_nxt   = 1'b1;
            // Winner drops to lowest priority for the next round
            w_ptr_nxt = (w_rr_y == '0) ? C_PTR_TOP : (w_rr_y - 1'b1);
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y   <= '0;
            r_v   <= 1'b0;
            r_ptr <= C_PTR_TOP;
        end else begin
            r_y   <= w_y_nxt;
            r_v   <= w_v_nxt;
            r_ptr <= w_ptr_nxt;
        end
    end

    assign y = r_y;
    assign v = r_v;

endmodule
`default_nettype wire

// File: tb/tb_codpri_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_codpri_rr
// Description : Directed self-checking bench for codpri_rr (N=4 and N=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_codpri_rr;

    logic       clk;
    logic       rst_n;
    logic [3:0] req4;
    logic [2:0] req3;
    logic       en;
    logic       modo;
    logic       hold;
    logic [1:0] y4;
    logic       v4;
    logic [1:0] y3;
    logic       v3;

    int n_checks;
    int n_errors;

    codpri_rr #(.N(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req4),
        .en    (en),
        .modo  (modo),
        .hold  (hold),
        .y     (y4),
        .v     (v4)
    );

    codpri_rr #(.N(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req3),
        .en    (en),
        .modo  (modo),
        .hold  (hold),
        .y     (y3),
        .v     (v3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input int ey, input int ev);
        chk({tag, ".y"}, int'(y4), ey);
        chk({tag, ".v"}, int'(v4), ev);
    endtask

    // Hand-computed highest-set-bit table for req = 0..15
    int hi_tab [16] = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};
    int rr_seq [6]  = '{3, 2, 1, 0, 3, 2};
    int sp_seq [4]  = '{3, 1, 3, 1};
    int n3_seq [4]  = '{2, 1, 0, 2};

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; req4 = 4'b1111; req3 = 3'b111;
        en = 1'b1; modo = 1'b1; hold = 1'b0;

        // Reset held for two edges
        step(); chk4("rst0", 0, 0);
        step(); chk4("rst1", 0, 0);

        // Round-robin fairness from reset
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(); chk4($sformatf("rr%0d", i), rr_seq[i], 1);
        end

        // Disable mid-rotation; ptr retained (last winner 2 -> ptr 1)
        en = 1'b0;
        step(); chk4("dis0", 0, 0);
        step(); chk4("dis1", 0, 0);
        en = 1'b1;
        step(); chk4("reen", 1, 1);

        // Reset, then sparse pattern and wrap
        rst_n = 1'b0; step(); chk4("rst2", 0, 0);
        rst_n = 1'b1;
        req4 = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step(); chk4($sformatf("sp%0d", i), sp_seq[i], 1);
        end
        req4 = 4'b0001; step(); chk4("wrap0", 0, 1);
        req4 = 4'b1111; step(); chk4("wrap3", 3, 1);

        // Hold: lock on 3, then release by dropping req[3]
        rst_n = 1'b0; step();
        rst_n = 1'b1; req4 = 4'b1111;
        step(); chk4("hgrant", 3, 1);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(); chk4($sformatf("hold%0d", i), 3, 1);
        end
        req4 = 4'b0111;
        step(); chk4("hdrop", 2, 1);
        step(); chk4("hlock2", 2, 1);

        // Reset while locked
        rst_n = 1'b0; step(); chk4("hrst", 0, 0);
        rst_n = 1'b1; hold = 1'b0; req4 = 4'b1111;
        step(); chk4("hrst_nx", 3, 1);

        // Hold with no live grant has no effect (ptr is 2 after grant 3)
        req4 = 4'b0000; step(); chk4("idle", 0, 0);
        hold = 1'b1; req4 = 4'b1111;
        step(); chk4("hold_v0", 2, 1);
        hold = 1'b0;

        // Fixed-priority sweep
        modo = 1'b0;
        for (int r = 0; r < 16; r++) begin
            req4 = 4'(r);
            step(); chk4($sformatf("fix%0d", r), hi_tab[r], (r != 0) ? 1 : 0);
        end

        // Disabled in fixed mode
        en = 1'b0;
        for (int r = 15; r > 0; r -= 5) begin
            req4 = 4'(r);
            step(); chk4($sformatf("fdis%0d", r), 0, 0);
        end
        en = 1'b1;

        // Mode switches: fixed -> RR starts at N-1; RR -> fixed -> RR restarts
        modo = 1'b1; req4 = 4'b1111;
        step(); chk4("sw_rr0", 3, 1);
        step(); chk4("sw_rr1", 2, 1);
        modo = 1'b0; req4 = 4'b0011;
        step(); chk4("sw_fx", 1, 1);
        modo = 1'b1; req4 = 4'b1111;
        step(); chk4("sw_rr2", 3, 1);

        // N=3 rotation
        rst_n = 1'b0; step();
        chk("n3rst.y", int'(y3), 0);
        chk("n3rst.v", int'(v3), 0);
        rst_n = 1'b1; req3 = 3'b111;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("n3rr%0d.y", i), int'(y3), n3_seq[i]);
            chk($sformatf("n3rr%0d.v", i), int'(v3), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
